// File: rtl/fsquare.sv
// Single-precision squarer: y = x*x with a 24-cycle radix-2 shift-add mantissa
// multiplier, truncating normalisation, zero flush and infinity saturation.
module fsquare (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0] Y_ZERO = 32'h0000_0000;
    localparam logic [31:0] Y_INF  = 32'h7F80_0000;
    localparam logic [31:0] Y_NAN  = 32'h7FC0_0000;

    state_t      state_q, state_d;
    logic [23:0] m_q, m_d;
    logic [47:0] p_q, p_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  exp_q, exp_d;
    logic [31:0] y_q, y_d;
    logic        out_valid_q, out_valid_d;

    logic [24:0] step_add_s;
    logic [47:0] p_step_s;
    logic        sign_unused_s;

    // Normalise the top product bits with exponent 2E-bias and pack, saturating/flushing.
    function automatic logic [31:0] pack_square(input logic [24:0] p_top, input logic [7:0] e);
        logic signed [9:0] ey;
        logic [22:0]       frac;
        logic [31:0]       res;
        if (p_top[24]) begin
            frac = p_top[23:1];
            ey   = $signed({1'b0, e, 1'b0}) - 10'sd126;
        end else begin
            frac = p_top[22:0];
            ey   = $signed({1'b0, e, 1'b0}) - 10'sd127;
        end
        if (ey >= 10'sd255) begin
            res = Y_INF;
        end else if (ey <= 10'sd0) begin
            res = Y_ZERO;
        end else begin
            res = {1'b0, ey[7:0], frac};
        end
        return res;
    endfunction

    assign sign_unused_s = x[31];
    assign step_add_s    = {1'b0, p_q[47:24]} + (m_q[cnt_q] ? {1'b0, m_q} : 25'd0);
    assign p_step_s      = {step_add_s, p_q[23:1]};

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (x[30:23] == 8'd0) begin
                        y_d         = Y_ZERO;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (x[30:23] == 8'hFF) begin
                        y_d         = (x[22:0] != 23'd0) ? Y_NAN : Y_INF;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        m_d     = {1'b1, x[22:0]};
                        p_d     = 48'd0;
                        cnt_d   = 5'd0;
                        exp_d   = x[30:23];
                        state_d = S_MUL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                p_d = p_step_s;
                if (cnt_q == 5'd23) begin
                    y_d         = pack_square(p_step_s[47:23], exp_q);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            m_q         <= 24'd0;
            p_q         <= 48'd0;
            cnt_q       <= 5'd0;
            exp_q       <= 8'd0;
            y_q         <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule

// File: tb/tb_fsquare.sv
// Self-checking bench for fsquare: directed cases plus random operands against a
// real-arithmetic squaring model with truncation, flushing and saturation.
module tb_fsquare;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y;

    int n_tests = 0;
    int n_fail  = 0;

    fsquare dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y)
    );

    always #5 clk = ~clk;

    // Exact square in double precision, then truncate to single.
    function automatic logic [31:0] model(input logic [31:0] v);
        logic [7:0]  e;
        logic [63:0] b;
        real         r;
        int          ey;
        e = v[30:23];
        if (e == 8'd0) return 32'h0000_0000;
        if (e == 8'hFF) return (v[22:0] != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
        b  = {1'b0, 11'(int'(e) + 896), v[22:0], 29'd0};
        r  = $bitstoreal(b);
        b  = $realtobits(r * r);
        ey = int'(b[62:52]) - 896;
        if (ey >= 255) return 32'h7F80_0000;
        if (ey <= 0) return 32'h0000_0000;
        return {1'b0, ey[7:0], b[51:29]};
    endfunction

    function automatic int exp_latency(input logic [31:0] v);
        return (v[30:23] == 8'd0 || v[30:23] == 8'hFF) ? 0 : 24;
    endfunction

    task automatic send(input logic [31:0] v);
        int k;
        in_valid = 1'b1;
        x = v;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = $urandom;
    endtask

    // Counts edges after the accept edge until out_valid; flags in_ready seen high.
    task automatic wait_out(output int cyc, output logic ready_seen);
        cyc = 0;
        ready_seen = 1'b0;
        while (!out_valid && cyc < 100) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || y !== 32'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: out_valid=%b y=%h in_ready=%b, want 0 00000000 1", out_valid, y, in_ready);
        end
    endtask

    task automatic test_basic();
        int cyc;
        logic rdy;
        send(32'h4040_0000);
        wait_out(cyc, rdy);
        n_tests++;
        if (cyc !== 24) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 24", cyc);
        end
        n_tests++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_in_ready: in_ready high during MUL");
        end
        n_tests++;
        if (y !== 32'h4110_0000) begin
            n_fail++;
            $display("FAIL basic_y: got %h want 41100000", y);
        end
        take_out();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_after_hs: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs [3] = '{32'h4000_0000, 32'hBFC0_0000, 32'h437F_0000};
        logic [31:0] ys [3] = '{32'h4080_0000, 32'h4010_0000, 32'h477E_0100};
        int cyc;
        logic rdy;
        for (int i = 0; i < 3; i++) begin
            send(xs[i]);
            wait_out(cyc, rdy);
            n_tests++;
            if (y !== ys[i] || cyc !== 24) begin
                n_fail++;
                $display("FAIL b2b_%0d: y=%h lat=%0d want %h lat=24", i, y, cyc, ys[i]);
            end
            take_out();
        end
    endtask

    task automatic test_specials();
        logic [31:0] xs [5] = '{32'h0000_0000, 32'h7FC0_0001, 32'hFF80_0000, 32'h7F00_0000, 32'h1F80_0000};
        logic [31:0] ys [5] = '{32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h7F80_0000, 32'h0000_0000};
        int          lat [5] = '{0, 0, 0, 24, 24};
        int cyc;
        logic rdy;
        for (int i = 0; i < 5; i++) begin
            send(xs[i]);
            wait_out(cyc, rdy);
            n_tests++;
            if (y !== ys[i] || cyc !== lat[i] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL special_%0d: x=%h y=%h lat=%0d want %h lat=%0d", i, xs[i], y, cyc, ys[i], lat[i]);
            end
            take_out();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic rdy;
        logic bad;
        logic [31:0] held;
        send(32'h3FC0_0000);
        wait_out(cyc, rdy);
        held = y;
        n_tests++;
        if (held !== 32'h4010_0000) begin
            n_fail++;
            $display("FAIL bp_y: got %h want 40100000", held);
        end
        bad = 1'b0;
        in_valid = 1'b1;
        x = 32'h4040_0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (y !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
        end
        in_valid = 1'b0;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_hold: y=%h in_ready=%b out_valid=%b want %h 0 1", y, in_ready, out_valid, held);
        end
        take_out();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== held) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b y=%h want 0 1 %h", out_valid, in_ready, y, held);
        end
    endtask

    task automatic test_reset_midop();
        int cyc;
        logic rdy;
        send(32'h4120_0000);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || y !== 32'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_reset: out_valid=%b y=%h in_ready=%b want 0 00000000 1", out_valid, y, in_ready);
        end
        send(32'h4040_0000);
        wait_out(cyc, rdy);
        n_tests++;
        if (y !== 32'h4110_0000 || cyc !== 24) begin
            n_fail++;
            $display("FAIL midop_fresh: y=%h lat=%0d want 41100000 lat=24", y, cyc);
        end
        take_out();
    endtask

    task automatic test_random();
        int cyc;
        logic rdy;
        logic [31:0] v;
        logic [31:0] want;
        for (int i = 0; i < 60; i++) begin
            v = $urandom;
            if (i % 4 != 0) v[30:23] = 8'($urandom_range(1, 254));
            want = model(v);
            send(v);
            wait_out(cyc, rdy);
            n_tests++;
            if (y !== want || cyc !== exp_latency(v) || rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL random_%0d: x=%h y=%h lat=%0d want %h lat=%0d", i, v, y, cyc, want, exp_latency(v));
            end
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            take_out();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_specials();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsquare.md
FSQUARE -- requirements
Module: fsquare

Interface
REQ-001 The block SHALL have these ports:
  clk        in   1   rising-edge clock
  rst        in   1   synchronous, active-high reset
  in_valid   in   1   x is valid
  in_ready   out  1   block can accept an operand
  x          in   32  IEEE-754 single operand
  out_valid  out  1   y is valid
  out_ready  in   1   consumer takes y
  y          out  32  IEEE-754 single result, x*x
REQ-002 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst.

Function
REQ-003 The block SHALL implement a state machine with exactly three states:
  - IDLE: waits for an operand.
  - MUL: computes the product.
  - DONE: holds the result.
REQ-004 in_ready SHALL be combinational and equal to (state==IDLE).
REQ-005 A handshake SHALL occur on the edge where in_valid && in_ready; x is captured on that edge.
REQ-006 Special operands SHALL be decided on the accept edge, with no MUL pass; the block writes y, goes to DONE, and asserts out_valid from the next cycle:
  - exp==0 (zero or denormal) -> 0x00000000
  - exp==255, frac!=0 (NaN) -> 0x7FC00000
  - exp==255, frac==0 (infinity) -> 0x7F800000
REQ-007 For a normal operand, the accept edge SHALL:
  - load the multiplicand M={1,frac} (24 b),
  - clear the 48-b accumulator P,
  - load the step counter with 0,
  - enter MUL.
REQ-008 MUL SHALL perform one radix-2 shift-add step per cycle, over mantissa bits 0..23, for exactly 24 cycles; the counter wraps nowhere.
REQ-009 On the 24th MUL edge, the block SHALL normalise, pack y, assert out_valid and enter DONE.
  - Latency is 24 cycles from the accept edge to out_valid high.
REQ-010 Normalisation SHALL use E = the biased input exponent and truncate (no rounding):
  - If P[47]: frac_y=P[46:24] and ey=2E-126.
  - Else: frac_y=P[45:23] and ey=2E-127.
  - ey SHALL be computed at 10 b, signed.
REQ-011 If ey>=255, y SHALL be 0x7F800000; if ey<=0, y SHALL be 0x00000000 (flush, no denormals).
REQ-012 The sign of y SHALL always be 0; the input sign is ignored.
REQ-013 In DONE, y and out_valid SHALL stay stable until out_valid && out_ready.
  - On that edge: out_valid->0 and state->IDLE.
  - y keeps its last value.
REQ-014 in_ready SHALL be 0 in MUL and DONE.
  - x and in_valid are ignored there.
  - A new operand is accepted no earlier than the cycle after the output handshake, so there is no result overlap.
REQ-015 out_ready in IDLE or MUL SHALL have no effect.
REQ-016 No result SHALL ever be dropped or duplicated; each accepted operand produces exactly one output handshake.

Reset
REQ-017 While rst is high at a rising edge, the block SHALL set:
  - state=IDLE,
  - out_valid=0,
  - y=0,
  - P=0,
  - counter=0.
REQ-018 Reset SHALL take priority over any handshake on the same edge.
REQ-019 Reset during MUL or DONE SHALL discard the operation in flight.
  - in_ready is 1 in the first cycle after reset is released.
REQ-020 Outputs are undefined before the first reset.

Verification
REQ-021 x=0x40400000 (3.0), out_ready=1 -> y=0x41100000 (9.0); out_valid is high exactly 24 cycles after the accept edge, and in_ready is low for those cycles.
REQ-022 The sequence 0x40000000, 0xBFC00000, 0x437F0000, each sent back-to-back as soon as in_ready is high, SHALL give y = 0x40800000, 0x40100000, 0x477E0100, in order.
REQ-023 Specials SHALL give these results, with out_valid one cycle after accept:
  - 0x00000000 -> 0x00000000
  - 0x7FC00001 -> 0x7FC00000
  - 0xFF800000 -> 0x7F800000
  - 0x7F000000 -> 0x7F800000 (normal operand: follows REQ-009, with overflow per REQ-011)
  - 0x1F800000 -> 0x00000000 (normal operand: underflow per REQ-011)
REQ-024 Backpressure: with out_ready held 0 for 10 cycles after out_valid, y stays constant and in_ready stays 0; raising out_ready completes one handshake, and in_ready goes to 1 on the next cycle.
REQ-025 Reset mid-op: assert rst at MUL step 12 -> next cycle out_valid=0, y=0, in_ready=1; then a fresh 0x40400000 -> 0x41100000 with full 24-cycle latency.
REQ-026 Random normal operands SHALL match a reference model of squaring with truncation, flushing and saturation, with the output sign forced to 0.
